// File: rtl/s27_sig_analyzer_if.sv
// rtl/s27_sig_analyzer_if.sv - response-side bus of the s27 signature analyzer
// ABORT exists only when S27_SIG_ABORT_EN is defined.
interface s27_sig_analyzer_if #(
  parameter int SIG_W = 16
);
  logic             START;
  logic             G17;
  logic             BUSY;
  logic             DONE;
  logic             PASS;
  logic [SIG_W-1:0] SIG;
`ifdef S27_SIG_ABORT_EN
  logic             ABORT;
`endif

  modport master (
`ifdef S27_SIG_ABORT_EN
    output ABORT,
`endif
    output START,
    output G17,
    input  BUSY,
    input  DONE,
    input  PASS,
    input  SIG
  );

  modport slave (
`ifdef S27_SIG_ABORT_EN
    input  ABORT,
`endif
    input  START,
    input  G17,
    output BUSY,
    output DONE,
    output PASS,
    output SIG
  );
endinterface

// File: rtl/s27_sig_analyzer.sv
// rtl/s27_sig_analyzer.sv - warm-up, CRC-style compaction of G17 and golden compare
// Optional run abort input is built in when S27_SIG_ABORT_EN is defined.
module s27_sig_analyzer #(
  parameter int               SIG_W   = 16,
  parameter logic [SIG_W-1:0] POLY    = 16'h1021,
  parameter logic [SIG_W-1:0] SEED    = '0,
  parameter int               WARM    = 3,
  parameter int               WIN_LEN = 64,
  parameter logic [SIG_W-1:0] GOLDEN  = '0
) (
  input  logic                CK,
  input  logic                RST,
  s27_sig_analyzer_if.slave   bus
);

  localparam int MAX_CNT = (WARM > WIN_LEN) ? WARM : WIN_LEN;
  localparam int CNT_W   = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'((WARM > 0) ? WARM - 1 : 0);
  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WIN_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [SIG_W-1:0] sig_shift;
  logic             fb;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             abort;

`ifdef S27_SIG_ABORT_EN
  assign abort = bus.ABORT;
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sig_d     = sig_q;
    pass_d    = pass_q;
    fb        = sig_q[SIG_W-1] ^ bus.G17;
    sig_shift = {sig_q[SIG_W-2:0], 1'b0} ^ (fb ? POLY : '0);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.START) begin
          sig_d   = SEED;
          cnt_d   = '0;
          pass_d  = 1'b0;
          state_d = (WARM == 0) ? ST_CAPTURE : ST_WARMUP;
        end
      end
      ST_WARMUP: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          sig_d   = '0;
        end else if (cnt_q == WARM_LAST) begin
          state_d = ST_CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          sig_d   = '0;
        end else begin
          sig_d = sig_shift;
          // Verdict is taken from the final signature on the same edge it lands.
          if (cnt_q == WIN_LAST) begin
            state_d = ST_DONE;
            cnt_d   = '0;
            pass_d  = (sig_shift == GOLDEN);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        sig_d   = '0;
        pass_d  = 1'b0;
      end
    endcase

    busy_d = (state_d == ST_WARMUP) || (state_d == ST_CAPTURE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sig_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.PASS = pass_q;
  assign bus.SIG  = sig_q;

endmodule

// File: tb/tb_s27_sig_analyzer.sv
// tb/tb_s27_sig_analyzer.sv - randomized self-checking bench for s27_sig_analyzer
// ABORT scenarios are exercised when S27_SIG_ABORT_EN is defined.
module tb_s27_sig_analyzer;

  logic ck = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 ck = ~ck;

  s27_sig_analyzer_if #(.SIG_W(16)) ia ();
  s27_sig_analyzer_if #(.SIG_W(16)) ib ();
  s27_sig_analyzer_if #(.SIG_W(16)) ic ();
  s27_sig_analyzer_if #(.SIG_W(16)) id ();

  s27_sig_analyzer #(.WARM(0), .WIN_LEN(1), .GOLDEN(16'h1021)) dut_a (.CK(ck), .RST(rst), .bus(ia));
  s27_sig_analyzer #(.WARM(3), .WIN_LEN(2), .GOLDEN(16'h2042)) dut_b (.CK(ck), .RST(rst), .bus(ib));
  s27_sig_analyzer                                             dut_c (.CK(ck), .RST(rst), .bus(ic));
  s27_sig_analyzer #(.GOLDEN(16'h0001))                        dut_d (.CK(ck), .RST(rst), .bus(id));

  // Signature as the remainder-style division of the sample stream, bit by bit.
  function automatic logic [15:0] model_sig(input logic [15:0] seed, input bit bits[$]);
    logic [15:0] s;
    s = seed;
    foreach (bits[i]) begin
      if (s[15] ^ bits[i]) s = (s << 1) ^ 16'h1021;
      else                 s = s << 1;
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic test_reset();
    logic [18:0] got;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    got = {ic.BUSY, ic.DONE, ic.PASS, ic.SIG};
    checks++;
    if (got !== 19'h0) begin
      errors++;
      $display("FAIL reset_state_c: got %h expected %h", got, 19'h0);
    end
    got = {ia.BUSY, ia.DONE, ia.PASS, ia.SIG};
    checks++;
    if (got !== 19'h0) begin
      errors++;
      $display("FAIL reset_state_a: got %h expected %h", got, 19'h0);
    end
    for (int i = 0; i < 10; i++) begin
      ic.G17 = 1'($urandom);
      tick();
      got = {ic.BUSY, ic.DONE, ic.PASS, ic.SIG};
      checks++;
      if (got !== 19'h0) begin
        errors++;
        $display("FAIL idle_hold cycle %0d: got %h expected %h", i, got, 19'h0);
      end
    end
  endtask

  task automatic test_single_sample();
    logic [18:0] got;
    ia.START = 1'b1;
    ia.G17   = 1'b1;
    tick();
    ia.START = 1'b0;
    checks++;
    if ({ia.BUSY, ia.DONE} !== 2'b10) begin
      errors++;
      $display("FAIL single_busy: got %b expected %b", {ia.BUSY, ia.DONE}, 2'b10);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      ia.G17 = 1'($urandom);
      got = {ia.BUSY, ia.DONE, ia.PASS, ia.SIG};
      checks++;
      if (got !== {3'b011, 16'h1021}) begin
        errors++;
        $display("FAIL single_done hold %0d: got %h expected %h", i, got, {3'b011, 16'h1021});
      end
      tick();
    end
  endtask

  task automatic test_warm_window();
    logic [18:0] got;
    ib.START = 1'b1;
    ib.G17   = 1'b1;
    tick();
    ib.START = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      ib.G17 = (k <= 3) ? 1'($urandom) : (k == 4) ? 1'b1 : 1'b0;
      tick();
      if (k < 5) begin
        checks++;
        if ({ib.BUSY, ib.DONE} !== 2'b10) begin
          errors++;
          $display("FAIL warm_busy edge %0d: got %b expected %b", k, {ib.BUSY, ib.DONE}, 2'b10);
        end
      end
    end
    got = {ib.BUSY, ib.DONE, ib.PASS, ib.SIG};
    checks++;
    if (got !== {3'b011, 16'h2042}) begin
      errors++;
      $display("FAIL warm_result: got %h expected %h", got, {3'b011, 16'h2042});
    end
  endtask

  // mode 0: G17 held low; 1: random G17; 2: random G17 plus stray mid-run START pulses
  task automatic test_default_run(input int mode);
    bit          q[$];
    bit          g;
    logic [15:0] exp;
    logic [18:0] got;
    ic.START = 1'b1;
    id.START = 1'b1;
    tick();
    ic.START = 1'b0;
    id.START = 1'b0;
    got = {ic.BUSY, ic.DONE, ic.PASS, ic.SIG};
    checks++;
    if (got !== {3'b100, 16'h0}) begin
      errors++;
      $display("FAIL run_start mode %0d: got %h expected %h", mode, got, {3'b100, 16'h0});
    end
    for (int k = 1; k <= 67; k++) begin
      g = (mode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      ic.G17 = g;
      id.G17 = g;
      if (k >= 4) q.push_back(g);
      ic.START = (mode == 2) && ($urandom_range(0, 7) == 0);
      id.START = ic.START;
      tick();
      if (k < 67) begin
        checks++;
        if ({ic.BUSY, ic.DONE, id.BUSY, id.DONE} !== 4'b1010) begin
          errors++;
          $display("FAIL run_busy mode %0d edge %0d: got %b expected %b", mode, k,
                   {ic.BUSY, ic.DONE, id.BUSY, id.DONE}, 4'b1010);
        end
      end
    end
    ic.START = 1'b0;
    id.START = 1'b0;
    exp = model_sig(16'h0000, q);
    got = {ic.BUSY, ic.DONE, ic.PASS, ic.SIG};
    checks++;
    if (got !== {2'b01, (exp == 16'h0000), exp}) begin
      errors++;
      $display("FAIL run_result_c mode %0d: got %h expected %h", mode, got, {2'b01, (exp == 16'h0000), exp});
    end
    got = {id.BUSY, id.DONE, id.PASS, id.SIG};
    checks++;
    if (got !== {2'b01, (exp == 16'h0001), exp}) begin
      errors++;
      $display("FAIL run_result_d mode %0d: got %h expected %h", mode, got, {2'b01, (exp == 16'h0001), exp});
    end
  endtask

  task automatic test_reset_mid_run();
    logic [18:0] got;
    ic.START = 1'b1;
    id.START = 1'b1;
    tick();
    ic.START = 1'b0;
    id.START = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      ic.G17 = 1'($urandom);
      id.G17 = ic.G17;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got = {ic.BUSY, ic.DONE, ic.PASS, ic.SIG};
    checks++;
    if (got !== 19'h0) begin
      errors++;
      $display("FAIL midrun_reset: got %h expected %h", got, 19'h0);
    end
    for (int k = 0; k < 70; k++) begin
      ic.G17 = 1'($urandom);
      tick();
      checks++;
      if ({ic.BUSY, ic.DONE} !== 2'b00) begin
        errors++;
        $display("FAIL midrun_no_done cycle %0d: got %b expected %b", k, {ic.BUSY, ic.DONE}, 2'b00);
      end
    end
    rst      = 1'b1;
    ic.START = 1'b1;
    tick();
    rst      = 1'b0;
    ic.START = 1'b0;
    checks++;
    if ({ic.BUSY, ic.DONE, ic.SIG} !== 18'h0) begin
      errors++;
      $display("FAIL reset_over_start: got %h expected %h", {ic.BUSY, ic.DONE, ic.SIG}, 18'h0);
    end
  endtask

`ifdef S27_SIG_ABORT_EN
  task automatic test_abort();
    logic [18:0] got;
    ib.START = 1'b1;
    tick();
    ib.START = 1'b0;
    ib.ABORT = 1'b1;
    tick();
    ib.ABORT = 1'b0;
    got = {ib.BUSY, ib.DONE, ib.PASS, ib.SIG};
    checks++;
    if (got !== 19'h0) begin
      errors++;
      $display("FAIL abort_warmup: got %h expected %h", got, 19'h0);
    end
    ib.START = 1'b1;
    tick();
    ib.START = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      ib.G17 = (k == 4) ? 1'b1 : 1'($urandom);
      tick();
    end
    checks++;
    if ({ib.BUSY, ib.SIG} !== {1'b1, 16'h1021}) begin
      errors++;
      $display("FAIL abort_pre_capture: got %h expected %h", {ib.BUSY, ib.SIG}, {1'b1, 16'h1021});
    end
    ib.ABORT = 1'b1;
    tick();
    ib.ABORT = 1'b0;
    got = {ib.BUSY, ib.DONE, ib.PASS, ib.SIG};
    checks++;
    if (got !== 19'h0) begin
      errors++;
      $display("FAIL abort_capture: got %h expected %h", got, 19'h0);
    end
    test_warm_window();
    ib.ABORT = 1'b1;
    tick();
    tick();
    ib.ABORT = 1'b0;
    got = {ib.BUSY, ib.DONE, ib.PASS, ib.SIG};
    checks++;
    if (got !== {3'b011, 16'h2042}) begin
      errors++;
      $display("FAIL abort_in_done: got %h expected %h", got, {3'b011, 16'h2042});
    end
  endtask
`endif

  initial begin
    ia.START = 1'b0; ia.G17 = 1'b0;
    ib.START = 1'b0; ib.G17 = 1'b0;
    ic.START = 1'b0; ic.G17 = 1'b0;
    id.START = 1'b0; id.G17 = 1'b0;
`ifdef S27_SIG_ABORT_EN
    ia.ABORT = 1'b0; ib.ABORT = 1'b0; ic.ABORT = 1'b0; id.ABORT = 1'b0;
`endif
    test_reset();
    test_single_sample();
    test_warm_window();
    test_default_run(0);
    test_default_run(1);
    test_default_run(2);
    test_reset_mid_run();
    test_default_run(1);
`ifdef S27_SIG_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
